// File: rtl/tilelink_ul_mem.sv
// TileLink-UL memory slave backing a small word-addressed window with a register array.
// Services Get, PutFullData and PutPartialData, including multi-beat bursts. Any other
// request, or one outside the window, still has its full beat count consumed and answered,
// but the response carries the error flag and memory is left untouched. One transaction
// is outstanding at a time.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   channel_a_*           request channel (slave side): opcode/param/size/source/address/
//                         mask/data, valid in, ready out
//   channel_d_*           response channel: opcode/param/size/source/sink/data/error,
//                         valid out, ready in
module tilelink_ul_mem #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned WORDS_LOG2 = 4,
  parameter int unsigned MAX_SIZE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  output logic        channel_a_ready,
  input  logic        channel_a_valid,
  input  logic [2:0]  channel_a_bits_opcode,
  input  logic [2:0]  channel_a_bits_param,
  input  logic [3:0]  channel_a_bits_size,
  input  logic        channel_a_bits_source,
  input  logic [31:0] channel_a_bits_address,
  input  logic [3:0]  channel_a_bits_mask,
  input  logic [31:0] channel_a_bits_data,
  input  logic        channel_d_ready,
  output logic        channel_d_valid,
  output logic [2:0]  channel_d_bits_opcode,
  output logic [1:0]  channel_d_bits_param,
  output logic [3:0]  channel_d_bits_size,
  output logic        channel_d_bits_source,
  output logic        channel_d_bits_sink,
  output logic [31:0] channel_d_bits_data,
  output logic        channel_d_bits_error
);

  localparam int unsigned Words = 1 << WORDS_LOG2;
  localparam logic [32:0] WinLo = {1'b0, BASE_ADDR};
  localparam logic [32:0] WinHi = WinLo + 33'(4 * Words);

  typedef enum logic [1:0] {StIdle, StPutBeats, StGetResp, StPutResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              size_q, size_d;
  logic                    source_q, source_d;
  logic [WORDS_LOG2-1:0]   idx_q, idx_d;
  logic                    err_q, err_d;
  // Beats still to go after the current one.
  logic [13:0]             rem_q, rem_d;
  logic [31:0]             mem_q [Words];
  logic [31:0]             mem_d [Words];

  logic                    a_fire;
  logic [32:0]             a_span, a_end;
  logic [31:0]             a_off;
  logic                    a_aligned, a_in_win, a_opc_ok, a_size_ok, a_err, a_is_get;
  logic [13:0]             a_beats_m1;
  logic [WORDS_LOG2-1:0]   a_idx;
  logic                    wr_en;
  logic [WORDS_LOG2-1:0]   wr_idx;

  logic unused_a;
  assign unused_a = ^{channel_a_bits_param, a_off[1:0], a_off[31:WORDS_LOG2+2]};

  assign a_fire = channel_a_valid && channel_a_ready;

  // First-beat decode: legality, beat count and starting word.
  always_comb begin
    a_span     = 33'd1 << channel_a_bits_size;
    a_end      = {1'b0, channel_a_bits_address} + a_span;
    a_aligned  = (channel_a_bits_address & (a_span[31:0] - 32'd1)) == 32'd0;
    // 33-bit compare so a window ending at 4 GiB or a wrapping range is handled.
    a_in_win   = ({1'b0, channel_a_bits_address} >= WinLo) && (a_end <= WinHi);
    a_opc_ok   = channel_a_bits_opcode inside {3'd0, 3'd1, 3'd4};
    a_size_ok  = 32'(channel_a_bits_size) <= MAX_SIZE;
    a_err      = !(a_opc_ok && a_size_ok && a_aligned && a_in_win);
    a_is_get   = channel_a_bits_opcode == 3'd4;
    a_off      = channel_a_bits_address - BASE_ADDR;
    a_idx      = a_off[WORDS_LOG2+1:2];
    a_beats_m1 = (channel_a_bits_size <= 4'd2) ? 14'd0
                 : (14'd1 << (channel_a_bits_size - 4'd2)) - 14'd1;
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    source_d = source_q;
    idx_d    = idx_q;
    err_d    = err_q;
    rem_d    = rem_q;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (a_fire) begin
          size_d   = channel_a_bits_size;
          source_d = channel_a_bits_source;
          err_d    = a_err;
          rem_d    = a_beats_m1;
          if (a_is_get) begin
            idx_d   = a_idx;
            state_d = StGetResp;
          end else begin
            // Anything that is not a Get takes the write path; bad opcodes are
            // error-flagged, so they drain their beats without writing.
            wr_en   = !a_err;
            wr_idx  = a_idx;
            idx_d   = a_idx + WORDS_LOG2'(1);
            state_d = (a_beats_m1 == 14'd0) ? StPutResp : StPutBeats;
          end
        end
      end
      StPutBeats: begin
        if (a_fire) begin
          wr_en = !err_q;
          idx_d = idx_q + WORDS_LOG2'(1);
          rem_d = rem_q - 14'd1;
          if (rem_q == 14'd1) state_d = StPutResp;
        end
      end
      StGetResp: begin
        if (channel_d_ready) begin
          if (rem_q == 14'd0) begin
            state_d = StIdle;
          end else begin
            rem_d = rem_q - 14'd1;
            idx_d = idx_q + WORDS_LOG2'(1);
          end
        end
      end
      StPutResp: begin
        if (channel_d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte-lane write merge.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (channel_a_bits_mask[b]) mem_d[wr_idx][8*b +: 8] = channel_a_bits_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      size_q   <= '0;
      source_q <= 1'b0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rem_q    <= '0;
      for (int unsigned i = 0; i < Words; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      source_q <= source_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      rem_q    <= rem_d;
      mem_q    <= mem_d;
    end
  end

  // D outputs depend only on registered state and the memory read mux.
  always_comb begin
    channel_a_ready       = !reset && (state_q == StIdle || state_q == StPutBeats);
    channel_d_valid       = 1'b0;
    channel_d_bits_opcode = 3'd0;
    channel_d_bits_param  = 2'd0;
    channel_d_bits_size   = 4'd0;
    channel_d_bits_source = 1'b0;
    channel_d_bits_sink   = 1'b0;
    channel_d_bits_data   = 32'd0;
    channel_d_bits_error  = 1'b0;
    if (state_q == StGetResp || state_q == StPutResp) begin
      channel_d_valid       = 1'b1;
      channel_d_bits_opcode = (state_q == StGetResp) ? 3'd1 : 3'd0;
      channel_d_bits_size   = size_q;
      channel_d_bits_source = source_q;
      channel_d_bits_error  = err_q;
      if (state_q == StGetResp && !err_q) channel_d_bits_data = mem_q[idx_q];
    end
  end

endmodule

// File: tb/tb_tilelink_ul_mem.sv
// Bench for tilelink_ul_mem: directed cases plus randomized traffic, checked against a
// word-array model of the memory window and a queue of expected D beats.
module tb_tilelink_ul_mem;
  localparam logic [31:0] Base = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_ready, a_valid = 1'b0;
  logic [2:0]  a_opcode = '0, a_param = '0;
  logic [3:0]  a_size = '0, a_mask = '0;
  logic        a_source = 1'b0;
  logic [31:0] a_address = '0, a_data = '0;
  logic        d_ready = 1'b1, d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_source, d_sink, d_error;
  logic [31:0] d_data;
  logic [43:0] d_pack;

  tilelink_ul_mem #(.BASE_ADDR(Base), .WORDS_LOG2(4), .MAX_SIZE(6)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .channel_a_ready       (a_ready),
    .channel_a_valid       (a_valid),
    .channel_a_bits_opcode (a_opcode),
    .channel_a_bits_param  (a_param),
    .channel_a_bits_size   (a_size),
    .channel_a_bits_source (a_source),
    .channel_a_bits_address(a_address),
    .channel_a_bits_mask   (a_mask),
    .channel_a_bits_data   (a_data),
    .channel_d_ready       (d_ready),
    .channel_d_valid       (d_valid),
    .channel_d_bits_opcode (d_opcode),
    .channel_d_bits_param  (d_param),
    .channel_d_bits_size   (d_size),
    .channel_d_bits_source (d_source),
    .channel_d_bits_sink   (d_sink),
    .channel_d_bits_data   (d_data),
    .channel_d_bits_error  (d_error)
  );

  assign d_pack = {d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error};

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [2:0]  opc;
    logic [3:0]  size;
    logic        src;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
    bit          last;
  } exp_t;

  int          n_checks = 0;
  int          n_errs = 0;
  int          dr_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 never
  bit          a_final = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] d_log[$];
  logic [2:0]  last_opc;
  logic [31:0] last_data;
  logic        last_err, last_src;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic bit model_err(input logic [2:0] op, input logic [3:0] sz,
                                   input logic [31:0] addr);
    longint unsigned a    = 64'(addr);
    longint unsigned span = 64'd1 << sz;
    bit bad = 1'b0;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) bad = 1'b1;
    if (sz > 4'd6) bad = 1'b1;
    if (a % span != 0) bad = 1'b1;
    if (a < 64'(Base) || a + span > 64'(Base) + 64) bad = 1'b1;
    return bad;
  endfunction

  // D-ready pattern generator.
  initial forever begin
    @(posedge clock);
    #1;
    case (dr_mode)
      0:       d_ready = 1'b1;
      1:       d_ready = !d_ready;
      2:       d_ready = 1'($urandom_range(0, 1));
      default: d_ready = 1'b0;
    endcase
  end

  // Compare process: every cycle out of reset.
  initial begin
    bit          resp_due = 1'b0, after_last = 1'b0, stalled = 1'b0;
    logic [43:0] held = '0;
    exp_t        e;
    forever begin
      @(negedge clock);
      if (reset) begin
        resp_due = 1'b0; after_last = 1'b0; stalled = 1'b0;
      end else begin
        if (resp_due) chk("d_latency", d_valid, 1);
        if (after_last) chk("a_ready_rise", {a_ready, d_valid}, 2'b10);
        if (stalled) chk("d_stable", {d_valid, d_pack}, {1'b1, held});
        if (d_valid) begin
          chk("a_ready_busy", a_ready, 0);
          chk("d_param_sink", {d_param, d_sink}, 0);
        end
        after_last = 1'b0;
        if (d_valid && d_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL d_unexpected: got a D beat, required none (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("d_opcode", d_opcode, e.opc);
            chk("d_size", d_size, e.size);
            chk("d_source", d_source, e.src);
            chk("d_error", d_error, e.err);
            if (e.chk_data) chk("d_data", d_data, e.data);
            after_last = e.last;
          end
          last_opc = d_opcode; last_data = d_data; last_err = d_error; last_src = d_source;
          d_log.push_back(d_data);
        end
        stalled  = d_valid && !d_ready;
        held     = d_pack;
        resp_due = a_valid && a_ready && a_final;
      end
    end
  end

  task automatic send_beat(input logic [2:0] op, input logic [3:0] sz, input logic src,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input bit fin, output bit ok);
    int t = 0;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    a_mask = mask; a_data = data; a_param = 3'($urandom); a_final = fin;
    @(negedge clock);
    while (!a_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    ok = a_ready;
    if (!ok) begin
      n_checks++; n_errs++;
      $display("FAIL a_handshake_timeout: a_ready=0, required 1 (t=%0t)", $time);
      a_valid = 1'b0; a_final = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      a_valid = 1'b0; a_final = 1'b0;
    end
  endtask

  // One transaction: drives all A beats and queues the D beats the model predicts.
  task automatic txn(input logic [2:0] op, input logic [3:0] sz, input logic src,
                     input logic [31:0] addr, input logic [31:0] data0,
                     input logic [3:0] mask0, input bit rnd);
    bit          err   = model_err(op, sz, addr);
    int          beats = (sz <= 4'd2) ? 1 : (1 << (sz - 4'd2));
    int          idx   = int'(((addr - Base) >> 2) & 32'hF);
    bit          ok;
    exp_t        e;
    logic [31:0] d;
    logic [3:0]  m;
    if (op == 3'd4) begin
      send_beat(op, sz, src, addr, 4'($urandom), $urandom, 1'b1, ok);
      if (!ok) return;
      for (int k = 0; k < beats; k++) begin
        e.opc = 3'd1; e.size = sz; e.src = src; e.err = err; e.chk_data = 1'b1;
        e.data = err ? 32'd0 : model_mem[(idx + k) % 16];
        e.last = (k == beats - 1);
        exp_q.push_back(e);
      end
    end else begin
      for (int b = 0; b < beats; b++) begin
        d = rnd ? $urandom : data0 + 32'(b);
        m = rnd ? ((op == 3'd0) ? 4'hF : 4'($urandom)) : mask0;
        send_beat(op, sz, src, addr, m, d, b == beats - 1, ok);
        if (!ok) return;
        if (!err) begin
          for (int l = 0; l < 4; l++) if (m[l]) model_mem[(idx + b) % 16][8*l +: 8] = d[8*l +: 8];
        end
      end
      e.opc = 3'd0; e.size = sz; e.src = src; e.err = err; e.chk_data = 1'b0;
      e.data = 32'd0; e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || d_valid) && t < 3000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 3000) begin
      n_checks++; n_errs++;
      $display("FAIL drain_timeout: %0d D beats outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [31:0] ad;
    int          r;
    foreach (model_mem[i]) model_mem[i] = '0;

    // Reset values.
    repeat (2) @(negedge clock);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_bits", d_pack, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("a_ready_after_rst", a_ready, 1);
    @(posedge clock); #1;

    // PutFull then Get.
    txn(3'd0, 4'd2, 1'b1, Base + 32'h4, 32'hDEADBEEF, 4'hF, 1'b0); drain();
    chk("put_ack_opc", last_opc, 0);
    chk("put_ack_err", last_err, 0);
    txn(3'd4, 4'd2, 1'b1, Base + 32'h4, 0, 0, 1'b0); drain();
    chk("get_opc", last_opc, 1);
    chk("get_data", last_data, 32'hDEADBEEF);
    chk("get_src", last_src, 1);

    // PutPartial lower two lanes.
    txn(3'd1, 4'd2, 1'b0, Base + 32'h4, 32'h0000_1234, 4'h3, 1'b0); drain();
    txn(3'd4, 4'd2, 1'b0, Base + 32'h4, 0, 0, 1'b0); drain();
    chk("partial_data", last_data, 32'hDEAD1234);

    // Bursts; Get with toggling backpressure.
    d_log.delete();
    txn(3'd0, 4'd4, 1'b0, Base + 32'h30, 32'd1, 4'hF, 1'b0); drain();
    chk("burst_ack_count", d_log.size(), 1);
    chk("burst_ack_opc", last_opc, 0);
    d_log.delete();
    dr_mode = 1;
    txn(3'd4, 4'd4, 1'b1, Base + 32'h30, 0, 0, 1'b0); drain();
    dr_mode = 0;
    chk("burst_beats", d_log.size(), 4);
    for (int k = 0; k < d_log.size(); k++) chk("burst_beat_data", d_log[k], 64'(k + 1));

    // Errors.
    txn(3'd4, 4'd2, 1'b0, 32'h0002_0000, 0, 0, 1'b0); drain();
    chk("oob_err", last_err, 1);
    chk("oob_data", last_data, 0);
    txn(3'd2, 4'd2, 1'b0, Base + 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0); drain();
    chk("badop_opc", last_opc, 0);
    chk("badop_err", last_err, 1);
    txn(3'd4, 4'd2, 1'b0, Base + 32'h4, 0, 0, 1'b0); drain();
    chk("badop_mem_kept", last_data, 32'hDEAD1234);
    txn(3'd4, 4'd2, 1'b0, Base + 32'h2, 0, 0, 1'b0); drain();
    chk("misaligned_err", last_err, 1);

    // Back-to-back with a_valid kept high between requests.
    txn(3'd4, 4'd2, 1'b1, Base + 32'h4, 0, 0, 1'b0);
    txn(3'd0, 4'd2, 1'b0, Base + 32'h8, 32'hCAFE_F00D, 4'hF, 1'b0);
    txn(3'd4, 4'd2, 1'b0, Base + 32'h8, 0, 0, 1'b0);
    drain();
    chk("b2b_data", last_data, 32'hCAFE_F00D);
    chk("model_pin", model_mem[2], 32'hCAFE_F00D);

    // Reset in the middle of a stalled Get burst.
    txn(3'd0, 4'd2, 1'b0, Base, 32'h55, 4'hF, 1'b0); drain();
    dr_mode = 3;
    txn(3'd4, 4'd4, 1'b0, Base + 32'h30, 0, 0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    foreach (model_mem[i]) model_mem[i] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("midrst_a_ready", a_ready, 0);
      chk("midrst_d_valid", d_valid, 0);
      chk("midrst_d_bits", d_pack, 0);
    end
    @(posedge clock); #1 reset = 1'b0;
    dr_mode = 0;
    txn(3'd4, 4'd2, 1'b0, Base, 0, 0, 1'b0); drain();
    chk("post_rst_data", last_data, 0);
    chk("post_rst_err", last_err, 0);

    // Randomized traffic with random backpressure.
    dr_mode = 2;
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = 3'd4;
      else if (r < 6) op = 3'd0;
      else if (r < 9) op = 3'd1;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == 3'd4) op = 3'd2;
      end
      sz = ($urandom_range(0, 5) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 8));
      case ($urandom_range(0, 9))
        0:       ad = $urandom;
        1:       ad = Base + 32'($urandom_range(0, 63));
        2:       ad = Base + 32'd60;
        default: ad = Base + (32'($urandom_range(0, 63)) & ~((32'd1 << sz) - 32'd1));
      endcase
      txn(op, sz, 1'($urandom), ad, 32'd0, 4'd0, 1'b1);
    end
    drain();
    dr_mode = 0;
    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
